serial_capture_reg: RTL

SERIAL_CAPTURE_REG -- requirements
Module: serial_capture_reg

---
 rtl/serial_capture_reg.sv | 95 +++++++++
 1 files changed

// File: rtl/serial_capture_reg.sv
// Serial-to-parallel capture register: assembles WIDTH-bit words LSB- or MSB-first
// and hands them to a consumer through a one-word holding register with Valid/Ack.
module serial_capture_reg #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           SerialIn,
  input  logic                           ShiftEn,
  input  logic                           ShiftRight,
  input  logic                           Sync,
  input  logic                           Ack,
  input  logic                           ClearOvr,
  output logic [WIDTH-1:0]               DataOut,
  output logic                           Valid,
  output logic                           Overrun,
  output logic [$clog2(WIDTH+1)-1:0]     BitCount
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic EMPTY = 1'b0;
  localparam logic HELD  = 1'b1;

  // Handshake: Valid=1 means DataOut carries an unconsumed word; the word is
  // consumed on any rising edge where Valid=1 and Ack=1. Ack while Valid=0 has no effect.

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    bit_count;
  logic             dir_lsb;
  logic             state;
  logic             eff_dir;
  logic             shift;
  logic             complete;
  logic             ovr_set;
  logic [WIDTH-1:0] sr_next;

  // The direction is taken live on the first bit of a word, from the latch afterwards.
  always_comb begin
    eff_dir  = (bit_count == '0) ? ShiftRight : dir_lsb;
    shift    = ShiftEn && !Sync;
    sr_next  = eff_dir ? {SerialIn, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], SerialIn};
    complete = shift && (bit_count == LAST_BIT);
    ovr_set  = (state == HELD) && complete && !Ack;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      bit_count <= '0;
      dir_lsb   <= 1'b1;
    end else if (Sync) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (ShiftEn) begin
      sr        <= sr_next;
      bit_count <= complete ? '0 : bit_count + 1'b1;
      if (bit_count == '0) dir_lsb <= ShiftRight;
    end
  end

  // Output FSM; the state bit itself drives Valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      DataOut <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            DataOut <= sr_next;
            state   <= HELD;
          end
        end
        HELD: begin
          if (complete && Ack) DataOut <= sr_next;
          else if (Ack)        state   <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Set beats clear when a word is lost on the same edge as ClearOvr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         Overrun <= 1'b0;
    else if (ovr_set)  Overrun <= 1'b1;
    else if (ClearOvr) Overrun <= 1'b0;
  end

  assign Valid    = state;
  assign BitCount = bit_count;

endmodule
